// File: rtl/l15_mem_responder.sv
`timescale 1ns/1ps
// L1.5-side memory responder: queues core load/store/ifill requests and answers
// them strictly in order from a line-organised SRAM after a fixed latency.
module l15_mem_responder #(
  parameter int ADDR_W     = 40,
  parameter int MEM_LINES  = 1024,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_l,
  input  logic              req_val_i,
  output logic              req_ack_o,
  input  logic [2:0]        req_type_i,
  input  logic [2:0]        req_size_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [63:0]       req_data_i,
  input  logic [1:0]        req_tid_i,
  output logic              rtrn_val_o,
  input  logic              rtrn_ack_i,
  output logic [2:0]        rtrn_type_o,
  output logic [1:0]        rtrn_tid_o,
  output logic [127:0]      rtrn_data_o,
  output logic [15:0]       err_cnt_o
);
  localparam int LINE_W = $clog2(MEM_LINES);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [2:0]        typ;
    logic [2:0]        size;
    logic [LINE_W-1:0] line;
    logic [3:0]        off;
    logic [63:0]       data;
    logic [1:0]        tid;
  } req_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  req_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           fifo_empty, fifo_full, push, pop;
  req_t           in_req, head, work;
  logic           work_err;
  state_t         state, state_next;
  logic [3:0]     timer, timer_next;
  logic           do_access, do_store, do_read;
  logic [15:0]    size_mask, be;
  logic [127:0]   wdata;
  logic [127:0]   mem [MEM_LINES];
  logic           unused_addr;

  // Address bits above the line index alias onto the same line.
  assign unused_addr = ^req_addr_i[ADDR_W-1:4+LINE_W];

  assign in_req = '{typ: req_type_i, size: req_size_i, line: req_addr_i[4+LINE_W-1:4],
                    off: req_addr_i[3:0], data: req_data_i, tid: req_tid_i};

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign req_ack_o  = req_val_i & ~fifo_full;
  assign push       = req_ack_o;
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= in_req;
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  function automatic logic is_legal(input req_t r);
    logic size_ok, align_ok;
    size_ok = (r.size <= 3'd3) || (r.size == 3'd7);
    case (r.size)
      3'd1:    align_ok = ~r.off[0];
      3'd2:    align_ok = ~|r.off[1:0];
      3'd3:    align_ok = ~|r.off[2:0];
      default: align_ok = 1'b1;
    endcase
    return (r.typ <= 3'd2) && size_ok && align_ok && !(r.typ == 3'd1 && r.size == 3'd7);
  endfunction

  always_ff @(posedge clk_i) begin
    if (pop) begin
      work     <= head;
      work_err <= ~is_legal(head);
    end
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    pop        = 1'b0;
    do_access  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          timer_next = 4'(LATENCY - 2);
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (timer == 4'd0) begin
          do_access  = 1'b1;
          state_next = ST_RESP;
        end else begin
          timer_next = timer - 4'd1;
        end
      end
      ST_RESP: begin
        if (rtrn_ack_i) begin
          if (!fifo_empty) begin
            // Popping straight from RESP skips the IDLE cycle, so wait one longer.
            pop        = 1'b1;
            timer_next = 4'(LATENCY - 1);
            state_next = ST_WAIT;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rtrn_val_o = (state == ST_RESP);

  always_comb begin
    case (work.size)
      3'd0:    size_mask = 16'h0001;
      3'd1:    size_mask = 16'h0003;
      3'd2:    size_mask = 16'h000F;
      3'd3:    size_mask = 16'h00FF;
      default: size_mask = 16'h0000;
    endcase
  end

  assign be       = size_mask << work.off;
  assign wdata    = {64'd0, work.data} << {work.off, 3'b000};
  assign do_store = do_access & ~work_err & (work.typ == 3'd1);
  assign do_read  = ~work_err & (work.typ != 3'd1);

  always_ff @(posedge clk_i) begin
    if (do_store) begin
      for (int b = 0; b < 16; b++) begin
        if (be[b]) mem[work.line][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      rtrn_type_o <= '0;
      rtrn_tid_o  <= '0;
      rtrn_data_o <= '0;
      err_cnt_o   <= '0;
    end else if (do_access) begin
      rtrn_type_o <= work_err ? 3'd7 : work.typ;
      rtrn_tid_o  <= work.tid;
      rtrn_data_o <= do_read ? mem[work.line] : 128'd0;
      if (work_err && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_l15_mem_responder.sv
`timescale 1ns/1ps
// Bench for l15_mem_responder: directed scenarios plus random traffic, all
// responses scored against a byte-array memory model and an in-order queue.
module tb_l15_mem_responder;
  localparam int ADDR_W = 40, MEM_LINES = 1024, LATENCY = 4, FIFO_DEPTH = 4;

  logic         clk = 1'b0, reset_l = 1'b1;
  logic         req_val = 1'b0, req_ack;
  logic [2:0]   req_type = '0, req_size = '0;
  logic [39:0]  req_addr = '0;
  logic [63:0]  req_data = '0;
  logic [1:0]   req_tid = '0;
  logic         rtrn_val, rtrn_ack = 1'b0;
  logic [2:0]   rtrn_type;
  logic [1:0]   rtrn_tid;
  logic [127:0] rtrn_data;
  logic [15:0]  err_cnt;

  always #5 clk = ~clk;

  l15_mem_responder #(.ADDR_W(ADDR_W), .MEM_LINES(MEM_LINES), .LATENCY(LATENCY),
                      .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk), .reset_l(reset_l), .req_val_i(req_val), .req_ack_o(req_ack),
    .req_type_i(req_type), .req_size_i(req_size), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_tid_i(req_tid), .rtrn_val_o(rtrn_val),
    .rtrn_ack_i(rtrn_ack), .rtrn_type_o(rtrn_type), .rtrn_tid_o(rtrn_tid),
    .rtrn_data_o(rtrn_data), .err_cnt_o(err_cnt));

  typedef struct {
    logic [2:0]   typ;
    logic [1:0]   tid;
    logic [127:0] data;
    int           acc;
  } exp_t;

  exp_t         exp_q[$];
  logic [7:0]   mem_m [MEM_LINES*16];
  int           n_checks = 0, n_errors = 0, cyc = 0, last_ack = 0, err_m = 0;
  bit           val_prev = 0, accepted = 0, rand_ack_en = 0, manual_ack = 0;
  logic [127:0] last_data = '0;
  logic [2:0]   last_type = '0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: decide legality from the request rules, apply stores to the byte
  // array immediately (responses are in order, so this equals pop-time effects).
  task automatic model_accept();
    exp_t e;
    int   line, off, nb;
    bit   legal;
    line  = int'((req_addr >> 4) % MEM_LINES);
    off   = int'(req_addr[3:0]);
    legal = (req_type <= 2) && (req_size <= 3 || req_size == 7) &&
            !(req_type == 1 && req_size == 7) &&
            (req_size == 7 || (off % (1 << req_size)) == 0);
    e.tid = req_tid;
    e.acc = cyc + 1;
    e.data = '0;
    if (!legal) e.typ = 3'd7;
    else begin
      e.typ = req_type;
      if (req_type == 1) begin
        nb = 1 << req_size;
        for (int k = 0; k < nb; k++) mem_m[line*16 + off + k] = req_data[8*k +: 8];
      end else begin
        for (int b = 0; b < 16; b++) e.data[8*b +: 8] = mem_m[line*16 + b];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    int base;
    accepted = 0;
    if (!reset_l) begin
      val_prev = 0;
      return;
    end
    if (rtrn_val) begin
      if (exp_q.size() == 0) check_eq("spurious_val", rtrn_val, 0);
      else begin
        if (!val_prev) begin
          if (exp_q[0].typ == 3'd7 && err_m < 65535) err_m++;
          base = (exp_q[0].acc > last_ack) ? exp_q[0].acc : last_ack;
          check_eq("latency", cyc, base + LATENCY);
          check_eq("err_cnt", err_cnt, err_m);
        end
        check_eq("rtrn_type", rtrn_type, exp_q[0].typ);
        check_eq("rtrn_tid", rtrn_tid, exp_q[0].tid);
        check_eq("rtrn_data", rtrn_data, exp_q[0].data);
        if (rtrn_ack) begin
          last_ack  = cyc + 1;
          last_data = rtrn_data;
          last_type = rtrn_type;
          void'(exp_q.pop_front());
        end
      end
    end
    val_prev = rtrn_val;
    if (req_val && req_ack) begin
      model_accept();
      accepted = 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    rtrn_ack = rand_ack_en ? ($urandom_range(0, 3) != 0) : manual_ack;
  endtask

  task automatic send(input logic [2:0] t, input logic [2:0] s, input logic [39:0] a,
                      input logic [63:0] d, input logic [1:0] tid);
    req_type = t; req_size = s; req_addr = a; req_data = d; req_tid = tid; req_val = 1'b1;
    for (int i = 0; i < 500; i++) begin
      step();
      if (accepted) break;
    end
    check_eq("send_accept", accepted, 1);
    req_val = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) step();
    check_eq("drain_empty", exp_q.size(), 0);
    repeat (2) step();
  endtask

  task automatic do_reset();
    req_val = 1'b0;
    reset_l = 1'b0;
    #1;
    check_eq("rst_val", rtrn_val, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    check_eq("rst_type", rtrn_type, 0);
    check_eq("rst_tid", rtrn_tid, 0);
    check_eq("rst_data", rtrn_data, 0);
    exp_q.delete();
    err_m = 0; last_ack = 0; val_prev = 0; accepted = 0;
    repeat (2) step();
    reset_l = 1'b1;
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  t, s;
    logic [39:0] a;
    int          r, off;
    #2;
    do_reset();

    // Give lines 0..8 known contents before anything reads them.
    rand_ack_en = 1;
    for (int l = 0; l <= 8; l++)
      for (int h = 0; h < 2; h++)
        send(3'd1, 3'd3, 40'(l*16 + h*8), {$urandom, $urandom}, 2'(h));
    drain();

    rand_ack_en = 0; manual_ack = 1;
    send(3'd1, 3'd3, 40'h80, 64'h1122334455667788, 2'd2); drain();
    check_eq("st_ack_type", last_type, 3'd1);
    send(3'd0, 3'd0, 40'h80, 64'd0, 2'd1); drain();
    check_eq("ld_after_st", last_data[63:0], 64'h1122334455667788);
    send(3'd1, 3'd0, 40'h8D, 64'hAB, 2'd3); drain();
    send(3'd2, 3'd7, 40'h80, 64'd0, 2'd0); drain();
    check_eq("byte13", last_data[111:104], 8'hAB);
    check_eq("ifill_type", last_type, 3'd2);
    send(3'd1, 3'd2, 40'h82, 64'hDEADBEEF, 2'd1); drain();
    check_eq("err_type", last_type, 3'd7);
    check_eq("err_data", last_data, 128'd0);
    check_eq("err_cnt_1", err_cnt, 16'd1);
    send(3'd5, 3'd0, 40'h80, 64'd0, 2'd2); drain();
    check_eq("err_cnt_2", err_cnt, 16'd2);
    send(3'd0, 3'd3, 40'h80, 64'd0, 2'd0); drain();
    check_eq("no_err_write", last_data[63:0], 64'h1122334455667788);
    send(3'd1, 3'd3, 40'h0000004000, 64'hCAFEF00D12345678, 2'd0); drain();
    send(3'd0, 3'd3, 40'h0, 64'd0, 2'd1); drain();
    check_eq("alias_load", last_data[63:0], 64'hCAFEF00D12345678);

    // Backpressure: five requests fit (one working + FIFO_DEPTH queued).
    manual_ack = 0;
    for (int i = 0; i < 6; i++) begin
      req_type = 3'd0; req_size = 3'd3; req_addr = 40'(i*16); req_data = '0;
      req_tid = 2'(i); req_val = 1'b1;
      step();
      check_eq("bp_ack", accepted, (i < 5));
    end
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("bp_hold_ack", accepted, 0);
    end
    check_eq("bp_val_held", rtrn_val, 1);
    manual_ack = 1;
    for (int i = 0; i < 200 && !accepted; i++) step();
    check_eq("bp_6th_accept", accepted, 1);
    req_val = 1'b0;
    drain();

    // Reset while a response is pending and two more are queued.
    manual_ack = 0;
    for (int i = 0; i < 3; i++) send(3'd0, 3'd3, 40'(i*16), 64'd0, 2'(i));
    for (int i = 0; i < 50 && !rtrn_val; i++) step();
    check_eq("pre_reset_val", rtrn_val, 1);
    do_reset();
    manual_ack = 1;
    send(3'd0, 3'd3, 40'h10, 64'd0, 2'd3); drain();
    check_eq("post_reset_type", last_type, 3'd0);
    repeat (20) step();

    // Random traffic with random response backpressure.
    rand_ack_en = 1;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      t = (r < 4) ? 3'd0 : (r < 7) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
      case ($urandom_range(0, 5))
        0: s = 3'd0;
        1: s = 3'd1;
        2: s = 3'd2;
        3: s = 3'd3;
        4: s = 3'd7;
        default: s = 3'($urandom_range(0, 7));
      endcase
      a = 40'({$urandom, $urandom});
      a[13:4] = 10'($urandom_range(0, 8));
      off = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1 && s <= 3) off = off & ~((1 << s) - 1);
      a[3:0] = 4'(off);
      send(t, s, a, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
      r = $urandom_range(0, 3);
      for (int g = 0; g < r; g++) step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/l15_mem_responder.md
Name: l15_mem_responder

Overview:
- Synthesizable L1.5-side responder: accepts core-side requests (load, store, ifill) over a val/ack request channel and returns in-order responses over a val/ack return channel.
- Requests are served from an internal line-organised SRAM model.
- Used as the far end of the HPDC/I$-to-L1.5 adapter in standalone tile simulation and FPGA bring-up, where no real L1.5/L2 exists.

Parameters:
- ADDR_W, 40, request address width.
- MEM_LINES, 1024, number of 16-byte lines in the backing store (power of 2).
- LATENCY, 4, cycles from request acceptance to response valid when idle; legal range 2..15.
- FIFO_DEPTH, 4, outstanding accepted-but-unanswered requests (power of 2).

Ports:
- clk_i  in  1  clock.
- reset_l  in  1  asynchronous active-low reset.
- req_val_i  in  1  request valid.
- req_ack_o  out  1  request accepted this cycle.
- req_type_i  in  3  request type: 0=LOAD, 1=STORE, 2=IFILL, others illegal.
- req_size_i  in  3  access size: 0=1B, 1=2B, 2=4B, 3=8B, 7=16B; others illegal.
- req_addr_i  in  ADDR_W  byte address.
- req_data_i  in  64  store data, little-endian.
- req_tid_i  in  2  thread id, echoed in the response.
- rtrn_val_o  out  1  response valid.
- rtrn_ack_i  in  1  response consumed.
- rtrn_type_o  out  3  response type: 0=LOAD_RET, 1=ST_ACK, 2=IFILL_RET, 7=ERR_RET.
- rtrn_tid_o  out  2  echoed thread id.
- rtrn_data_o  out  128  line data; byte i at bits [8i+7:8i].
- err_cnt_o  out  16  saturating count of ERR_RET responses issued.

Behaviour:
- Clock and reset: clk_i rising edge; reset_l asynchronous, active-low.
- Reset values:
  - req_ack_o=0, rtrn_val_o=0, rtrn_type_o=0, rtrn_tid_o=0, rtrn_data_o=0, err_cnt_o=0.
  - FIFO empty, FSM in IDLE.
  - SRAM contents are not reset.
- Reset mid-operation discards all queued and in-flight requests. No partial response survives. A store not yet performed is dropped.
- Request acceptance:
  - req_ack_o = req_val_i & ~fifo_full (combinational). A request is captured on any cycle where both are high.
  - At most one request per cycle. Full FIFO means req_ack_o=0; the requester holds its fields stable.
  - Acceptance and a FIFO pop in the same cycle are legal while the FIFO is full; ack is still gated by the registered full flag.
- Line indexing: line = req_addr_i[4+$clog2(MEM_LINES)-1:4]; upper address bits are ignored (aliasing). Offset = req_addr_i[3:0].
- Legality check, done at pop time. The request is illegal, returns ERR_RET with data=0, and causes no memory write if any of these hold:
  - type > 2;
  - size not in {0,1,2,3,7};
  - STORE with size 7;
  - offset not aligned to 2^size (size 7 requires offset 0 only for STORE; LOAD/IFILL ignore the size-7 alignment).
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if FIFO non-empty, pop head into the working register, load the timer with LATENCY-2, and go to WAIT.
  - WAIT: decrement the timer. When it reaches 0, perform the access, register the response fields, and go to RESP.
    - STORE: writes 2^size bytes; byte k of req_data_i goes to line byte offset+k.
    - LOAD and IFILL: read the full line.
  - RESP: rtrn_val_o=1 with all rtrn_* fields held stable until rtrn_ack_i=1.
    - On ack, if the FIFO is non-empty, pop the next head directly and enter WAIT. Otherwise go to IDLE.
- Latency:
  - Request acked in cycle T with the responder idle and the FIFO empty: rtrn_val_o rises at T+LATENCY.
  - Queued request: rtrn_val_o rises at A+LATENCY, where A is the ack cycle of the previous response.
- Ordering: responses are strictly in acceptance order. Memory effects happen in that order, so a LOAD after a STORE to the same line sees the stored bytes.
- Response data:
  - LOAD_RET and IFILL_RET return the full 16B line regardless of size.
  - ST_ACK and ERR_RET return data 0.
- err_cnt_o increments by 1 on the cycle an ERR_RET first becomes valid, and saturates at 16'hFFFF.
- rtrn_ack_i while rtrn_val_o=0 is ignored.

Test Plan:
- Store then load, LATENCY=4: STORE size=3 addr=0x80 data=0x1122334455667788 acked at T. ST_ACK valid at T+4 with tid echoed. Ack immediately, then LOAD addr=0x80 size=0. LOAD_RET data[63:0]=0x1122334455667788.
- Byte-lane placement: STORE size=0 addr=0x8D data=0xAB, then LOAD addr=0x80. Byte 13 of the response (bits [111:104]) equals 0xAB; other bytes are unchanged.
- Illegal requests: STORE size=2 addr=0x82 (misaligned) returns ERR_RET, data=0, no write, err_cnt_o=1. type=5 returns ERR_RET and err_cnt_o=2.
- Backpressure and full: 5 back-to-back requests with rtrn_ack_i held 0, FIFO_DEPTH=4. req_ack_o drops on the 6th offered cycle, or earlier per pops. The response holds stable for 20 cycles. Releasing ack yields 5 in-order responses spaced LATENCY cycles after each ack.
- Aliasing: STORE to addr 0x0000004000 (line index 0 wraps at MEM_LINES=1024) followed by LOAD of 0x0 returns the stored data.
- Reset mid-flight: assert reset_l=0 while in RESP with 2 queued requests. rtrn_val_o=0 asynchronously, err_cnt_o=0. After release, a new LOAD gets a response at T+LATENCY and no stale response appears.
